// File: rtl/ysyx_alu_pkg.sv
// Shared definitions for the RV32E execute-stage ALU.
// The bit positions of the one-hot alu_op vector and the vector width.
package ysyx_alu_pkg;

   localparam int ALU_OP_W = 17;

   localparam int ALU_ADD  = 0;
   localparam int ALU_SUB  = 1;
   localparam int ALU_SLT  = 2;
   localparam int ALU_SLTU = 3;
   localparam int ALU_AND  = 4;
   localparam int ALU_OR   = 5;
   localparam int ALU_XOR  = 6;
   localparam int ALU_SLL  = 7;
   localparam int ALU_SRL  = 8;
   localparam int ALU_SRA  = 9;
   localparam int ALU_LUI  = 10;
   localparam int ALU_BEQ  = 11;
   localparam int ALU_BNE  = 12;
   localparam int ALU_BLT  = 13;
   localparam int ALU_BGE  = 14;
   localparam int ALU_BLTU = 15;
   localparam int ALU_BGEU = 16;

endpackage

// File: rtl/ysyx_alu_cmp.sv
// Branch condition evaluator for the ALU.
// br_op is alu_op[16:11], ordered BEQ, BNE, BLT, BGE, BLTU, BGEU from bit 0 upward.
module ysyx_alu_cmp
   import ysyx_alu_pkg::*;
(
   input  logic [31:0] src3,
   input  logic [31:0] src4,
   input  logic [5:0]  br_op,
   output logic        cond
);

   logic eq;
   logic lt;
   logic ltu;

   assign eq  = (src3 == src4);
   assign lt  = ($signed(src3) < $signed(src4));
   assign ltu = (src3 < src4);

   // JAL/JALR carry no branch bit and are always taken; several bits OR together.
   always_comb begin
      cond = 1'b0;
      if (br_op == 6'd0) begin
         cond = 1'b1;
      end else begin
         cond = (br_op[ALU_BEQ  - ALU_BEQ] &  eq)
              | (br_op[ALU_BNE  - ALU_BEQ] & ~eq)
              | (br_op[ALU_BLT  - ALU_BEQ] &  lt)
              | (br_op[ALU_BGE  - ALU_BEQ] & ~lt)
              | (br_op[ALU_BLTU - ALU_BEQ] &  ltu)
              | (br_op[ALU_BGEU - ALU_BEQ] & ~ltu);
      end
   end

endmodule

// File: rtl/ysyx_alu.sv
// RV32E integer ALU: one-hot op select, AND-OR result mux, branch/jump mode.
// Defining ALU_OUT_REG_EN registers both outputs on posedge clk (1-cycle latency).
module ysyx_alu
   import ysyx_alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                double_cal,
   input  logic [ALU_OP_W-1:0] alu_op,
   input  logic [XLEN-1:0]     alu_src1,
   input  logic [XLEN-1:0]     alu_src2,
   input  logic [XLEN-1:0]     alu_src3,
   input  logic [XLEN-1:0]     alu_src4,
   output logic [XLEN-1:0]     alu_result1,
   output logic [XLEN-1:0]     alu_result2
);

   logic [XLEN-1:0] add_res;
   logic [XLEN-1:0] sub_res;
   logic [XLEN-1:0] slt_res;
   logic [XLEN-1:0] sltu_res;
   logic [XLEN-1:0] sll_res;
   logic [XLEN-1:0] srl_res;
   logic [XLEN-1:0] sra_res;
   logic [4:0]      shamt;
   logic            cond;
   logic [XLEN-1:0] res1_comb;
   logic [XLEN-1:0] res2_comb;

   assign shamt    = alu_src2[4:0];
   assign add_res  = alu_src1 + alu_src2;
   assign sub_res  = alu_src1 - alu_src2;
   assign slt_res  = {{(XLEN-1){1'b0}}, ($signed(alu_src1) < $signed(alu_src2))};
   assign sltu_res = {{(XLEN-1){1'b0}}, (alu_src1 < alu_src2)};
   assign sll_res  = alu_src1 << shamt;
   assign srl_res  = alu_src1 >> shamt;
   assign sra_res  = $signed(alu_src1) >>> shamt;

   ysyx_alu_cmp u_cmp (
      .src3  (alu_src3),
      .src4  (alu_src4),
      .br_op (alu_op[ALU_BGEU:ALU_BEQ]),
      .cond  (cond)
   );

   // Branch bits never feed result1 in normal mode; in branch mode result1 is the even target.
   always_comb begin
      res1_comb = '0;
      res2_comb = '0;
      if (double_cal) begin
         res1_comb = add_res & ~{{(XLEN-1){1'b0}}, 1'b1};
         res2_comb = {{(XLEN-1){1'b0}}, cond};
      end else begin
         res1_comb = ({XLEN{alu_op[ALU_ADD]}}  & add_res)
                   | ({XLEN{alu_op[ALU_SUB]}}  & sub_res)
                   | ({XLEN{alu_op[ALU_SLT]}}  & slt_res)
                   | ({XLEN{alu_op[ALU_SLTU]}} & sltu_res)
                   | ({XLEN{alu_op[ALU_AND]}}  & (alu_src1 & alu_src2))
                   | ({XLEN{alu_op[ALU_OR]}}   & (alu_src1 | alu_src2))
                   | ({XLEN{alu_op[ALU_XOR]}}  & (alu_src1 ^ alu_src2))
                   | ({XLEN{alu_op[ALU_SLL]}}  & sll_res)
                   | ({XLEN{alu_op[ALU_SRL]}}  & srl_res)
                   | ({XLEN{alu_op[ALU_SRA]}}  & sra_res)
                   | ({XLEN{alu_op[ALU_LUI]}}  & alu_src2);
      end
   end

`ifdef ALU_OUT_REG_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_result1 <= '0;
         alu_result2 <= '0;
      end else begin
         alu_result1 <= res1_comb;
         alu_result2 <= res2_comb;
      end
   end
`else
   // The combinational build has no use for clk/rst; fold them into an unused net.
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst;
   assign alu_result1    = res1_comb;
   assign alu_result2    = res2_comb;
`endif

endmodule

// File: tb/tb_ysyx_alu.sv
// Self-checking bench for ysyx_alu: directed vector table, random vs. reference model,
// and (when ALU_OUT_REG_EN is defined) latency and async-reset sequences.
module tb_ysyx_alu;
   import ysyx_alu_pkg::*;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                double_cal = 1'b0;
   logic [ALU_OP_W-1:0] alu_op = '0;
   logic [31:0]         alu_src1 = '0;
   logic [31:0]         alu_src2 = '0;
   logic [31:0]         alu_src3 = '0;
   logic [31:0]         alu_src4 = '0;
   logic [31:0]         alu_result1;
   logic [31:0]         alu_result2;

   int n_compared   = 0;
   int n_mismatched = 0;

   ysyx_alu #(.XLEN(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .double_cal  (double_cal),
      .alu_op      (alu_op),
      .alu_src1    (alu_src1),
      .alu_src2    (alu_src2),
      .alu_src3    (alu_src3),
      .alu_src4    (alu_src4),
      .alu_result1 (alu_result1),
      .alu_result2 (alu_result2)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [16:0] op;
      logic        dc;
      logic [31:0] s1;
      logic [31:0] s2;
      logic [31:0] s3;
      logic [31:0] s4;
      logic [31:0] exp1;
      logic [31:0] exp2;
   } vec_t;

   // Reference: evaluate each selected op straight from the ISA meaning and OR them.
   function automatic void model(input logic [16:0] op, input logic dc,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic [31:0] d,
                                 output logic [31:0] r1, output logic [31:0] r2);
      int signed   sa;
      int signed   sb;
      int signed   sc;
      int signed   sd;
      logic [31:0] t;
      logic        taken;
      sa = a; sb = b; sc = c; sd = d;
      r1 = 32'd0;
      r2 = 32'd0;
      if (dc) begin
         r1 = (a + b) & 32'hFFFF_FFFE;
         taken = (op[16:11] == 6'd0);
         for (int i = 11; i <= 16; i++) begin
            if (op[i]) begin
               case (i)
                  11: taken |= (c == d);
                  12: taken |= (c != d);
                  13: taken |= (sc < sd);
                  14: taken |= (sc >= sd);
                  15: taken |= (c < d);
                  default: taken |= (c >= d);
               endcase
            end
         end
         r2 = taken ? 32'd1 : 32'd0;
      end else begin
         for (int i = 0; i <= 10; i++) begin
            if (op[i]) begin
               case (i)
                  0: t = a + b;
                  1: t = a - b;
                  2: t = (sa < sb) ? 32'd1 : 32'd0;
                  3: t = (a < b) ? 32'd1 : 32'd0;
                  4: t = a & b;
                  5: t = a | b;
                  6: t = a ^ b;
                  7: t = a << (b % 32);
                  8: t = a >> (b % 32);
                  9: t = sa >>> (b % 32);
                  default: t = b;
               endcase
               r1 |= t;
            end
         end
      end
   endfunction

   task automatic applyStimulus(input logic [16:0] op, input logic dc,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c, input logic [31:0] d);
      alu_op     = op;
      double_cal = dc;
      alu_src1   = a;
      alu_src2   = b;
      alu_src3   = c;
      alu_src4   = d;
`ifdef ALU_OUT_REG_EN
      @(posedge clk);
      #1;
`else
      #2;
`endif
   endtask

   task automatic checkOutput(input string name, input logic [31:0] exp1, input logic [31:0] exp2);
      n_compared++;
      if (alu_result1 !== exp1) begin
         n_mismatched++;
         $display("[TB] FAIL %s result1: got %08h, expected %08h", name, alu_result1, exp1);
      end
      n_compared++;
      if (alu_result2 !== exp2) begin
         n_mismatched++;
         $display("[TB] FAIL %s result2: got %08h, expected %08h", name, alu_result2, exp2);
      end
   endtask

   function automatic logic [16:0] bit_of(input int i);
      logic [16:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   vec_t        vecs[$];
   logic [31:0] e1;
   logic [31:0] e2;
   logic [16:0] rop;
   logic        rdc;
   logic [31:0] ra, rb, rc, rd;

   initial begin
      vecs.push_back('{"add_wrap",  bit_of(ALU_ADD),  1'b0, 32'hFFFF_FFFF, 32'd1,        32'd0, 32'd0, 32'h0000_0000, 32'd0});
      vecs.push_back('{"sra_amt4",  bit_of(ALU_SRA),  1'b0, 32'h8000_0000, 32'h24,       32'd0, 32'd0, 32'hF800_0000, 32'd0});
      vecs.push_back('{"srl_amt4",  bit_of(ALU_SRL),  1'b0, 32'h8000_0000, 32'h24,       32'd0, 32'd0, 32'h0800_0000, 32'd0});
      vecs.push_back('{"sll_amt1",  bit_of(ALU_SLL),  1'b0, 32'h0000_0001, 32'h21,       32'd0, 32'd0, 32'h0000_0002, 32'd0});
      vecs.push_back('{"slt_neg",   bit_of(ALU_SLT),  1'b0, 32'hFFFF_FFFF, 32'd1,        32'd0, 32'd0, 32'd1,         32'd0});
      vecs.push_back('{"sltu_neg",  bit_of(ALU_SLTU), 1'b0, 32'hFFFF_FFFF, 32'd1,        32'd0, 32'd0, 32'd0,         32'd0});
      vecs.push_back('{"blt_tgt",   bit_of(ALU_BLT),  1'b1, 32'h8000_0000, 32'd8,        32'hFFFF_FFFB, 32'd3, 32'h8000_0008, 32'd1});
      vecs.push_back('{"bltu_tgt",  bit_of(ALU_BLTU), 1'b1, 32'h8000_0000, 32'd8,        32'hFFFF_FFFB, 32'd3, 32'h8000_0008, 32'd0});
      vecs.push_back('{"jalr",      bit_of(ALU_ADD),  1'b1, 32'h0000_1003, 32'd0,        32'd0, 32'd0, 32'h0000_1002, 32'd1});
      vecs.push_back('{"op_zero",   17'd0,            1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0, 32'd0,        32'd0});
      vecs.push_back('{"lui",       bit_of(ALU_LUI),  1'b0, 32'h1111_1111, 32'hABCD_E000, 32'd0, 32'd0, 32'hABCD_E000, 32'd0});
      vecs.push_back('{"and_or",    bit_of(ALU_AND) | bit_of(ALU_OR), 1'b0, 32'hF0, 32'h3C, 32'd0, 32'd0, 32'hFC, 32'd0});
      vecs.push_back('{"beq_nodc",  bit_of(ALU_BEQ),  1'b0, 32'd5, 32'd5,                32'd7, 32'd7, 32'd0,         32'd0});
      vecs.push_back('{"beq_bne",   bit_of(ALU_BEQ) | bit_of(ALU_BNE), 1'b1, 32'd100, 32'd4, 32'd1, 32'd2, 32'd104, 32'd1});
      vecs.push_back('{"bge_eq",    bit_of(ALU_BGE),  1'b1, 32'd0, 32'd0,                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1});
      vecs.push_back('{"sub_wrap",  bit_of(ALU_SUB),  1'b0, 32'd0, 32'd1,                32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0});

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_state", 32'd0, 32'd0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].op, vecs[i].dc, vecs[i].s1, vecs[i].s2, vecs[i].s3, vecs[i].s4);
         checkOutput(vecs[i].name, vecs[i].exp1, vecs[i].exp2);
      end

      for (int n = 0; n < 300; n++) begin
         rop = (n % 4 == 3) ? 17'($urandom) : bit_of(int'($urandom_range(0, 16)));
         rdc = 1'($urandom);
         ra  = $urandom;
         rb  = (n % 5 == 0) ? 32'($urandom_range(0, 63)) : $urandom;
         rc  = $urandom;
         rd  = (n % 3 == 0) ? rc : $urandom;
         model(rop, rdc, ra, rb, rc, rd, e1, e2);
         applyStimulus(rop, rdc, ra, rb, rc, rd);
         checkOutput("random", e1, e2);
      end

`ifdef ALU_OUT_REG_EN
      rst = 1'b1;
      #1;
      rst = 1'b0;
      @(negedge clk);
      alu_op = bit_of(ALU_ADD); double_cal = 1'b0; alu_src1 = 32'd2; alu_src2 = 32'd3;
      #1;
      checkOutput("reg_before_edge", 32'd0, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("reg_after_edge", 32'd5, 32'd0);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("reg_async_rst", 32'd0, 32'd0);
      rst = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
